// File: rtl/dram_rqst_master_if.sv
// Bus bundle between the DRAM request FIFO consumer and its two neighbours:
// the request FIFO read port and the PLB/DRAM master bus adapter.
interface dram_rqst_master_if #(
    parameter int DRAM_RQST_FIFO_DATA_WIDTH = 45
);
    logic [DRAM_RQST_FIFO_DATA_WIDTH-1:0] i_dram_rqst_fifo_data;
    logic                                 i_dram_rqst_fifo_empty;
    logic                                 o_dram_rqst_fifo_re;
    logic                                 o_mem_rqst;
    logic                                 o_mem_rnw;
    logic [31:0]                          o_mem_addr;
    logic [11:0]                          o_mem_length;
    logic                                 i_mem_ack;
    logic                                 i_mem_beat;
    logic                                 i_mem_cmplt;
    logic                                 i_mem_err;

    modport master (
        input  i_dram_rqst_fifo_data, i_dram_rqst_fifo_empty,
        input  i_mem_ack, i_mem_beat, i_mem_cmplt, i_mem_err,
        output o_dram_rqst_fifo_re,
        output o_mem_rqst, o_mem_rnw, o_mem_addr, o_mem_length
    );

    modport slave (
        output i_dram_rqst_fifo_data, i_dram_rqst_fifo_empty,
        output i_mem_ack, i_mem_beat, i_mem_cmplt, i_mem_err,
        input  o_dram_rqst_fifo_re,
        input  o_mem_rqst, o_mem_rnw, o_mem_addr, o_mem_length
    );
endinterface

// File: rtl/dram_rqst_master.sv
// Consumer of the DRAM request FIFO: pops {addr, length, rnw} entries and runs
// each as one DRAM bus transaction, with beat checking, timeout and debug status.
module dram_rqst_master #(
    parameter int DRAM_RQST_FIFO_DATA_WIDTH = 45,
    parameter int BEAT_BYTES_LOG2           = 3,
    parameter int TIMEOUT_CYCLES            = 4096,
    parameter int TIMEOUT_WIDTH             = 13
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    dram_rqst_master_if.master bus,
    output logic               o_busy,
    output logic               o_err,
    output logic [1:0]         o_err_code,
    output logic [2:0]         o_state,
    output logic [2:0]         o_completed_rqsts
);
    localparam int LEN_W  = 12;
    localparam int BEAT_W = LEN_W - BEAT_BYTES_LOG2 + 1;
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [LEN_W:0]           ROUND    = (LEN_W + 1)'((1 << BEAT_BYTES_LOG2) - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LATCH = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [31:0]              addr_q;
    logic [LEN_W-1:0]         len_q;
    logic                     rnw_q;
    logic [BEAT_W-1:0]        beat_cnt, beat_cnt_nxt, exp_beats;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
    logic                     err_q;
    logic [1:0]               err_code_q, err_code_nxt;
    logic [2:0]               done_cnt;

    logic [31:0]      fifo_addr;
    logic [LEN_W-1:0] fifo_len;
    logic             fifo_rnw;
    logic [LEN_W:0]   len_round;

    assign fifo_addr = bus.i_dram_rqst_fifo_data[DRAM_RQST_FIFO_DATA_WIDTH-1 -: 32];
    assign fifo_len  = bus.i_dram_rqst_fifo_data[LEN_W:1];
    assign fifo_rnw  = bus.i_dram_rqst_fifo_data[0];
    assign len_round = {1'b0, fifo_len} + ROUND;

    logic ack_hit, cmplt_hit, tmo_hit, zero_hit;
    assign ack_hit   = (state == ISSUE) && bus.i_mem_ack;
    assign cmplt_hit = (state == WAIT) && bus.i_mem_cmplt;
    assign tmo_hit   = (state == WAIT) && !bus.i_mem_cmplt && (tmo_cnt == TMO_LAST);
    assign zero_hit  = (state == LATCH) && (fifo_len == '0);

    // A beat arriving together with i_mem_cmplt still counts toward the total.
    assign beat_cnt_nxt = ((state == WAIT) && bus.i_mem_beat && (beat_cnt != '1))
                        ? beat_cnt + 1'b1 : beat_cnt;

    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        err_code_nxt = 2'b00;
        if (cmplt_hit) begin
            if (bus.i_mem_err)                  err_code_nxt = 2'b01;
            else if (beat_cnt_nxt != exp_beats) err_code_nxt = 2'b11;
        end else if (tmo_hit) begin
            err_code_nxt = 2'b10;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!bus.i_dram_rqst_fifo_empty) state_nxt = POP;
            POP:     state_nxt = LATCH;
            LATCH:   state_nxt = zero_hit ? IDLE : ISSUE;
            ISSUE:   if (bus.i_mem_ack) state_nxt = WAIT;
            WAIT:    if (bus.i_mem_cmplt || tmo_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The read strobe is gated by reset so it stays low while reset is held,
    // even with a non-empty FIFO in front of the IDLE state.
    always_comb begin
        bus.o_dram_rqst_fifo_re = i_rst_n && (state == IDLE) && !bus.i_dram_rqst_fifo_empty;
        bus.o_mem_rqst          = (state == ISSUE);
        o_busy                  = (state != IDLE);
        o_state                 = state;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q     <= '0;
            len_q      <= '0;
            rnw_q      <= 1'b0;
            beat_cnt   <= '0;
            exp_beats  <= '0;
            tmo_cnt    <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            done_cnt   <= 3'd0;
        end else begin
            if (state == LATCH) begin
                addr_q    <= fifo_addr;
                len_q     <= fifo_len;
                rnw_q     <= fifo_rnw;
                beat_cnt  <= '0;
                exp_beats <= BEAT_W'(len_round >> BEAT_BYTES_LOG2);
            end else begin
                beat_cnt <= beat_cnt_nxt;
            end

            if (ack_hit)              tmo_cnt <= '0;
            else if (state == WAIT)   tmo_cnt <= tmo_cnt + 1'b1;

            if (zero_hit || cmplt_hit || tmo_hit) done_cnt <= done_cnt + 3'd1;

            // First error wins: the code is frozen once the sticky flag is up.
            if (!err_q && (err_code_nxt != 2'b00)) begin
                err_q      <= 1'b1;
                err_code_q <= err_code_nxt;
            end
        end
    end

    assign bus.o_mem_addr   = addr_q;
    assign bus.o_mem_length = len_q;
    assign bus.o_mem_rnw    = rnw_q;
    assign o_err             = err_q;
    assign o_err_code        = err_code_q;
    assign o_completed_rqsts = done_cnt;
endmodule

// File: tb/tb_dram_rqst_master.sv
// Scoreboard bench for dram_rqst_master: a queue-backed FIFO model and bus
// responder; expected transactions and completion counts are queued at push time.
module tb_dram_rqst_master;
    localparam int TIMEOUT_CYCLES = 4096;

    typedef struct packed {
        logic [31:0] addr;
        logic [11:0] len;
        logic        rnw;
    } entry_t;

    logic       clk;
    logic       rst_n;
    logic       busy, err;
    logic [1:0] err_code;
    logic [2:0] state, completed;

    dram_rqst_master_if bus ();

    dram_rqst_master dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .bus               (bus),
        .o_busy            (busy),
        .o_err             (err),
        .o_err_code        (err_code),
        .o_state           (state),
        .o_completed_rqsts (completed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    entry_t     fifo_q[$];
    entry_t     exp_txn_q[$];
    logic [2:0] exp_done_q[$];
    logic [2:0] model_done;
    logic [2:0] done_prev;
    logic       rqst_prev;
    logic       last_re;
    int         re_cnt, re_empty_cnt, rqst_rises;
    int         n_cmp, n_bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_entry(input logic [31:0] addr, input logic [11:0] len, input logic rnw);
        entry_t e;
        e = '{addr: addr, len: len, rnw: rnw};
        fifo_q.push_back(e);
        if (len != 12'd0) exp_txn_q.push_back(e);
        model_done = model_done + 3'd1;
        exp_done_q.push_back(model_done);
    endtask

    task automatic sb_clear();
        fifo_q.delete();
        exp_txn_q.delete();
        exp_done_q.delete();
        model_done = 3'd0;
        done_prev  = 3'd0;
        rqst_prev  = 1'b0;
    endtask

    // One clock: sample the read strobe before the edge, update the FIFO model
    // after it, then run the request and completion monitors.
    task automatic tick();
        logic   do_pop;
        entry_t e;
        bus.i_dram_rqst_fifo_empty = (fifo_q.size() == 0);
        #1;
        do_pop  = bus.o_dram_rqst_fifo_re;
        last_re = do_pop;
        if (do_pop) begin
            re_cnt++;
            if (fifo_q.size() == 0) re_empty_cnt++;
        end
        @(posedge clk);
        #1;
        if (do_pop && fifo_q.size() != 0) bus.i_dram_rqst_fifo_data = fifo_q.pop_front();
        bus.i_dram_rqst_fifo_empty = (fifo_q.size() == 0);

        if (bus.o_mem_rqst && !rqst_prev) begin
            rqst_rises++;
            check("rqst_expected", exp_txn_q.size() > 0, 1);
            if (exp_txn_q.size() > 0) begin
                e = exp_txn_q.pop_front();
                check("mem_addr",   bus.o_mem_addr,   e.addr);
                check("mem_length", bus.o_mem_length, e.len);
                check("mem_rnw",    bus.o_mem_rnw,    e.rnw);
            end
        end
        rqst_prev = bus.o_mem_rqst;

        if (completed !== done_prev) begin
            check("done_expected", exp_done_q.size() > 0, 1);
            if (exp_done_q.size() > 0) check("completed_rqsts", completed, exp_done_q.pop_front());
            done_prev = completed;
        end
    endtask

    task automatic wait_rqst();
        int n;
        n = 0;
        while (!bus.o_mem_rqst && n < 200) begin
            tick();
            n++;
        end
        check("rqst_seen", bus.o_mem_rqst, 1);
    endtask

    task automatic run_txn(input int ack_dly, input int nbeats, input logic do_cmplt, input logic e);
        wait_rqst();
        repeat (ack_dly) tick();
        check("rqst_held", bus.o_mem_rqst, 1);
        bus.i_mem_ack = 1'b1;
        tick();
        bus.i_mem_ack = 1'b0;
        check("rqst_dropped", bus.o_mem_rqst, 0);
        for (int i = 0; i < nbeats; i++) begin
            bus.i_mem_beat = 1'b1;
            tick();
        end
        bus.i_mem_beat = 1'b0;
        if (do_cmplt) begin
            bus.i_mem_cmplt = 1'b1;
            bus.i_mem_err   = e;
            tick();
            bus.i_mem_cmplt = 1'b0;
            bus.i_mem_err   = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sb_clear();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n, re0, rises0;
        n_cmp = 0; n_bad = 0;
        re_cnt = 0; re_empty_cnt = 0; rqst_rises = 0;
        last_re = 1'b0;
        rst_n = 1'b0;
        bus.i_dram_rqst_fifo_data  = '0;
        bus.i_dram_rqst_fifo_empty = 1'b1;
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_beat  = 1'b0;
        bus.i_mem_cmplt = 1'b0;
        bus.i_mem_err   = 1'b0;
        sb_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",      busy, 0);
        check("rst_err",       err, 0);
        check("rst_err_code",  err_code, 0);
        check("rst_state",     state, 0);
        check("rst_completed", completed, 0);
        check("rst_mem_rqst",  bus.o_mem_rqst, 0);
        check("rst_mem_addr",  bus.o_mem_addr, 0);
        rst_n = 1'b1;

        // Stray bus responses in IDLE change nothing.
        bus.i_mem_ack = 1'b1; bus.i_mem_beat = 1'b1; bus.i_mem_cmplt = 1'b1;
        tick();
        bus.i_mem_ack = 1'b0; bus.i_mem_beat = 1'b0; bus.i_mem_cmplt = 1'b0;
        check("stray_completed", completed, 0);
        check("stray_busy",      busy, 0);

        // DRAM write, 0xFE0 bytes -> 508 beats.
        push_entry(32'h0010_0000, 12'hFE0, 1'b0);
        run_txn(2, 508, 1'b1, 1'b0);
        check("wr_err",       err, 0);
        check("wr_completed", completed, 1);
        check("wr_re_count",  re_cnt, 1);

        // DRAM read, 68 bytes -> 9 beats, then short by one beat.
        push_entry(32'h0000_2000, 12'h044, 1'b1);
        run_txn(0, 9, 1'b1, 1'b0);
        check("rd9_err", err, 0);
        push_entry(32'h0000_2000, 12'h044, 1'b1);
        run_txn(1, 8, 1'b1, 1'b0);
        check("rd8_err",      err, 1);
        check("rd8_err_code", err_code, 2'b11);

        // Zero length: no bus request, back in IDLE three cycles after the strobe.
        rises0 = rqst_rises;
        push_entry(32'h0000_3000, 12'h000, 1'b1);
        n = 0;
        do begin tick(); n++; end while (!last_re && n < 20);
        check("zero_re_seen", last_re, 1);
        check("zero_state_pop", state, 1);
        tick();
        check("zero_state_latch", state, 2);
        tick();
        check("zero_state_idle", state, 0);
        check("zero_completed",  completed, 4);
        check("zero_no_rqst",    rqst_rises, rises0);

        // Timeout, then a bus error that must not overwrite the first code.
        apply_reset();
        push_entry(32'h0000_4000, 12'h010, 1'b0);
        wait_rqst();
        bus.i_mem_ack = 1'b1;
        tick();
        bus.i_mem_ack = 1'b0;
        n = 0;
        while (busy && n < 5000) begin tick(); n++; end
        check("tmo_cycles",    n, TIMEOUT_CYCLES);
        check("tmo_err",       err, 1);
        check("tmo_err_code",  err_code, 2'b10);
        check("tmo_completed", completed, 1);
        push_entry(32'h0000_5000, 12'h008, 1'b1);
        run_txn(1, 1, 1'b1, 1'b1);
        check("buserr_err_code",  err_code, 2'b10);
        check("buserr_completed", completed, 2);

        // Nine back-to-back entries: count wraps 7 -> 0 -> 1.
        apply_reset();
        re0 = re_cnt;
        for (int i = 0; i < 9; i++)
            push_entry(32'h0001_0000 + 32'(i) * 32'h100, 12'(8 * (i + 1)), i[0]);
        for (int i = 0; i < 9; i++) run_txn(0, i + 1, 1'b1, 1'b0);
        repeat (10) tick();
        check("b2b_re_count",   re_cnt - re0, 9);
        check("b2b_re_empty",   re_empty_cnt, 0);
        check("b2b_completed",  completed, 1);
        check("b2b_err",        err, 0);
        check("b2b_busy",       busy, 0);
        check("b2b_sb_txn",     exp_txn_q.size(), 0);
        check("b2b_sb_done",    exp_done_q.size(), 0);

        // Asynchronous reset in the middle of WAIT.
        push_entry(32'h0000_6000, 12'h020, 1'b1);
        run_txn(0, 1, 1'b0, 1'b0);
        check("mid_state_wait", state, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_busy",      busy, 0);
        check("async_state",     state, 0);
        check("async_completed", completed, 0);
        check("async_mem_rqst",  bus.o_mem_rqst, 0);
        check("async_mem_addr",  bus.o_mem_addr, 0);
        check("async_mem_len",   bus.o_mem_length, 0);
        check("async_mem_rnw",   bus.o_mem_rnw, 0);
        sb_clear();
        tick();
        rst_n = 1'b1;
        re0 = re_cnt;
        bus.i_mem_cmplt = 1'b1;
        bus.i_mem_beat  = 1'b1;
        tick();
        bus.i_mem_cmplt = 1'b0;
        bus.i_mem_beat  = 1'b0;
        tick();
        check("late_cmplt_completed", completed, 0);
        check("late_cmplt_err",       err, 0);
        check("late_cmplt_busy",      busy, 0);
        check("late_cmplt_no_re",     re_cnt - re0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
